// File: rtl/exec_unit_alu_mul.sv
// Execution unit fed by the reservation stations: single-cycle ALU operations
// and a 64-cycle shift-add multiplier. Each result is held in an output register
// and driven onto the result bus until the bus grants it.
module exec_unit_alu_mul #(
    parameter int ROBsize    = 32,
    parameter int ROBsizeLog = $clog2(ROBsize + 1)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [63:0]           rsVal1_i,
    input  logic [63:0]           rsVal2_i,
    input  logic [9:0]            rsCommands_i,
    input  logic [ROBsizeLog-1:0] rsTag_i,
    input  logic                  rsReady_i,
    output logic                  stall_o,
    input  logic                  cdbGrant_i,
    output logic [64:0]           resultVal_o,
    output logic [ROBsizeLog-1:0] resultTag_o,
    output logic                  busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] OP_MUL = 4'd8;

    state_t                state_reg;
    logic [63:0]           mcand_reg;   // multiplicand, shifted left each MUL cycle
    logic [63:0]           mplier_reg;  // multiplier, shifted right each MUL cycle
    logic [63:0]           acc_reg;     // partial product
    logic [6:0]            cnt_reg;
    logic [ROBsizeLog-1:0] tag_reg;
    logic [63:0]           result_reg;

    logic [3:0]  opcode;
    logic [5:0]  shamt;
    logic [63:0] alu_res;
    logic [63:0] acc_next;
    logic        accept;
    logic        unused_cmd_bits;

    assign opcode          = rsCommands_i[3:0];
    assign shamt           = rsVal2_i[5:0];
    assign unused_cmd_bits = ^rsCommands_i[9:4];

    // Stall whenever the unit cannot take a new instruction this edge; in DONE a
    // grant frees the output register so a new instruction can slip in behind it.
    always_comb begin
        stall_o = ~reset_i | (state_reg == MUL) | ((state_reg == DONE) & ~cdbGrant_i);
        accept  = rsReady_i & ~stall_o;
    end

    // Single-cycle ALU, evaluated on the incoming operands so the result can be
    // registered on the accept edge.
    always_comb begin
        alu_res = 64'd0;
        case (opcode)
            4'd0:    alu_res = rsVal1_i + rsVal2_i;
            4'd1:    alu_res = rsVal1_i - rsVal2_i;
            4'd2:    alu_res = rsVal1_i & rsVal2_i;
            4'd3:    alu_res = rsVal1_i | rsVal2_i;
            4'd4:    alu_res = rsVal1_i ^ rsVal2_i;
            4'd5:    alu_res = rsVal1_i << shamt;
            4'd6:    alu_res = rsVal1_i >> shamt;
            4'd7:    alu_res = $signed(rsVal1_i) >>> shamt;
            4'd9:    alu_res = rsVal2_i;
            default: alu_res = 64'd0;
        endcase
    end

    // One shift-add step: add the multiplicand when the current multiplier bit is set.
    always_comb begin
        acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : 64'd0);
    end

    // Control FSM plus datapath registers; accept has priority so a granted
    // result can be followed by a new instruction with no bubble.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_reg  <= IDLE;
            mcand_reg  <= 64'd0;
            mplier_reg <= 64'd0;
            acc_reg    <= 64'd0;
            cnt_reg    <= 7'd0;
            tag_reg    <= '0;
            result_reg <= 64'd0;
        end else if (accept) begin
            mcand_reg  <= rsVal1_i;
            mplier_reg <= rsVal2_i;
            tag_reg    <= rsTag_i;
            acc_reg    <= 64'd0;
            cnt_reg    <= 7'd0;
            if (opcode == OP_MUL) begin
                state_reg <= MUL;
            end else begin
                result_reg <= alu_res;
                state_reg  <= DONE;
            end
        end else begin
            case (state_reg)
                MUL: begin
                    acc_reg    <= acc_next;
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    cnt_reg    <= cnt_reg + 7'd1;
                    if (cnt_reg == 7'd63) begin
                        result_reg <= acc_next;
                        state_reg  <= DONE;
                    end
                end
                DONE: begin
                    if (cdbGrant_i) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Result bus drive: only a held result is presented, everything else reads zero.
    always_comb begin
        busy_o = (state_reg != IDLE);
        if (state_reg == DONE) begin
            resultVal_o = {1'b1, result_reg};
            resultTag_o = tag_reg;
        end else begin
            resultVal_o = 65'd0;
            resultTag_o = '0;
        end
    end

endmodule

// File: tb/tb_exec_unit_alu_mul.sv
// Directed testbench for exec_unit_alu_mul: ALU ops, multiply latency, grant
// back-pressure, back-to-back issue, shifts and reset during a multiply.
module tb_exec_unit_alu_mul;

    localparam int TW = 6;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic [63:0]   rsVal1_i;
    logic [63:0]   rsVal2_i;
    logic [9:0]    rsCommands_i;
    logic [TW-1:0] rsTag_i;
    logic          rsReady_i;
    logic          stall_o;
    logic          cdbGrant_i;
    logic [64:0]   resultVal_o;
    logic [TW-1:0] resultTag_o;
    logic          busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    exec_unit_alu_mul #(.ROBsize(32)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .rsVal1_i    (rsVal1_i),
        .rsVal2_i    (rsVal2_i),
        .rsCommands_i(rsCommands_i),
        .rsTag_i     (rsTag_i),
        .rsReady_i   (rsReady_i),
        .stall_o     (stall_o),
        .cdbGrant_i  (cdbGrant_i),
        .resultVal_o (resultVal_o),
        .resultTag_o (resultTag_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [64:0] obs, input logic [64:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic issue(input logic [63:0] a, input logic [63:0] b,
                         input logic [3:0] op, input logic [TW-1:0] tag);
        rsVal1_i     = a;
        rsVal2_i     = b;
        rsCommands_i = {6'h2A, op};
        rsTag_i      = tag;
        rsReady_i    = 1'b1;
    endtask

    initial begin
        reset_i = 1'b0; rsVal1_i = '0; rsVal2_i = '0; rsCommands_i = '0;
        rsTag_i = '0; rsReady_i = 1'b0; cdbGrant_i = 1'b0;

        // Reset then idle
        tick();
        chk("stall_in_reset", 65'(stall_o), 65'd1);
        tick();
        chk("stall_in_reset2", 65'(stall_o), 65'd1);
        reset_i = 1'b1;
        #1;
        chk("idle_stall", 65'(stall_o), 65'd0);
        chk("idle_val", resultVal_o, 65'd0);
        chk("idle_tag", 65'(resultTag_o), 65'd0);
        chk("idle_busy", 65'(busy_o), 65'd0);

        // ADD wrap, then SUB back-to-back under grant
        cdbGrant_i = 1'b1;
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd0, 6'd3);
        tick();
        chk("add_val", resultVal_o, 65'h1_0000_0000_0000_0000);
        chk("add_tag", 65'(resultTag_o), 65'd3);
        issue(64'd0, 64'd1, 4'd1, 6'd5);
        #1;
        chk("b2b_stall", 65'(stall_o), 65'd0);
        tick();
        chk("sub_val", resultVal_o, 65'h1_FFFF_FFFF_FFFF_FFFF);
        chk("sub_tag", 65'(resultTag_o), 65'd5);
        rsReady_i = 1'b0;
        tick();
        chk("sub_idle_val", resultVal_o, 65'd0);
        chk("sub_idle_busy", 65'(busy_o), 65'd0);

        // MUL 3*5: 64 stalled cycles, then result
        cdbGrant_i = 1'b0;
        issue(64'd3, 64'd5, 4'd8, 6'd6);
        tick();
        rsReady_i = 1'b0;
        for (int i = 1; i <= 64; i++) begin
            chk($sformatf("mul_stall_c%0d", i), 65'(stall_o), 65'd1);
            chk($sformatf("mul_nval_c%0d", i), 65'(resultVal_o[64]), 65'd0);
            if (i == 1) chk("mul_busy", 65'(busy_o), 65'd1);
            tick();
        end
        chk("mul_val", resultVal_o, 65'h1_0000_0000_0000_000F);
        chk("mul_tag", 65'(resultTag_o), 65'd6);
        cdbGrant_i = 1'b1;
        tick();
        chk("mul_idle", 65'(busy_o), 65'd0);

        // MUL -2*7
        issue(64'hFFFF_FFFF_FFFF_FFFE, 64'd7, 4'd8, 6'd1);
        tick();
        rsReady_i = 1'b0;
        for (int i = 0; i < 64; i++) tick();
        chk("mulneg_val", resultVal_o, 65'h1_FFFF_FFFF_FFFF_FFF2);
        chk("mulneg_tag", 65'(resultTag_o), 65'd1);
        tick();

        // XOR held without grant; pending OR not captured; then back-to-back
        cdbGrant_i = 1'b0;
        issue(64'h0000_0000_0000_F0F0, 64'h0000_0000_0000_FF00, 4'd4, 6'd4);
        tick();
        issue(64'h0000_0000_0000_1200, 64'h0000_0000_0000_0034, 4'd3, 6'd9);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("hold_val_c%0d", i), resultVal_o, 65'h1_0000_0000_0000_0FF0);
            chk($sformatf("hold_tag_c%0d", i), 65'(resultTag_o), 65'd4);
            chk($sformatf("hold_stall_c%0d", i), 65'(stall_o), 65'd1);
            tick();
        end
        cdbGrant_i = 1'b1;
        #1;
        chk("grant_stall", 65'(stall_o), 65'd0);
        tick();
        chk("or_val", resultVal_o, 65'h1_0000_0000_0000_1234);
        chk("or_tag", 65'(resultTag_o), 65'd9);

        // Shifts, AND, PASSB, reserved opcode, all back-to-back
        issue(64'h8000_0000_0000_0000, 64'h44, 4'd7, 6'd2);
        tick();
        chk("sra_val", resultVal_o, 65'h1_F800_0000_0000_0000);
        chk("sra_tag", 65'(resultTag_o), 65'd2);
        issue(64'h8000_0000_0000_0000, 64'h44, 4'd6, 6'd10);
        tick();
        chk("srl_val", resultVal_o, 65'h1_0800_0000_0000_0000);
        issue(64'd1, 64'd63, 4'd5, 6'd11);
        tick();
        chk("sll_val", resultVal_o, 65'h1_8000_0000_0000_0000);
        issue(64'h0000_0000_00FF_00FF, 64'h0000_0000_000F_0F0F, 4'd2, 6'd12);
        tick();
        chk("and_val", resultVal_o, 65'h1_0000_0000_000F_000F);
        issue(64'h1111, 64'h1234_5678, 4'd9, 6'd13);
        tick();
        chk("passb_val", resultVal_o, 65'h1_0000_0000_1234_5678);
        issue(64'h1111, 64'h2222, 4'd12, 6'd14);
        tick();
        chk("op12_val", resultVal_o, 65'h1_0000_0000_0000_0000);
        chk("op12_tag", 65'(resultTag_o), 65'd14);
        rsReady_i = 1'b0;
        tick();

        // Reset during MUL at the 20th MUL cycle
        issue(64'd3, 64'd5, 4'd8, 6'd7);
        tick();
        rsReady_i = 1'b0;
        for (int i = 1; i < 20; i++) tick();
        reset_i = 1'b0;
        #1;
        chk("rst_stall", 65'(stall_o), 65'd1);
        tick();
        chk("rst_val", resultVal_o, 65'd0);
        chk("rst_busy", 65'(busy_o), 65'd0);
        reset_i = 1'b1;
        #1;
        chk("rst_rel_stall", 65'(stall_o), 65'd0);
        for (int i = 0; i < 70; i++) begin
            chk($sformatf("rst_noresult_c%0d", i), 65'(resultVal_o[64]), 65'd0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
